// File: rtl/stream_tb_pkg.sv
// Shared FSM encoding, LFSR constants and elaboration helpers for the
// streaming stimulus generator / output monitor blocks.
package stream_tb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
    localparam logic [15:0] LFSR_TAP_MASK     = 16'hB400;
    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

    function automatic int clog2(input int value);
        int width;
        for (width = 0; (width < 31) && ((1 << width) < value); width++) begin
        end
        return width;
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR; loads the seed on reset and advances every cycle.
module lfsr16
    import stream_tb_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    logic [15:0] lfsr_q;
    logic        feedback;

    assign feedback = ^(lfsr_q & LFSR_TAP_MASK);

    // NOTE: state is updated with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= seed;
        end else begin
            lfsr_q <= {lfsr_q[14:0], feedback};
        end
    end

    assign q = lfsr_q;

endmodule

// File: rtl/stream_stim_monitor.sv
// Drives a deterministic multi-frame pixel stream into the accelerator and
// counts/checksums its output beats, with optional LFSR-driven throttling.
module stream_stim_monitor
    import stream_tb_pkg::*;
#(
    parameter int          Nin                = 3,
    parameter int          Nout               = 3,
    parameter int          BIT_WIDTH          = 8,
    parameter int          INPUT_SPATIAL_DIM  = 25,
    parameter int          OUTPUT_SPATIAL_DIM = 9,
    parameter int          FRAME_SIZE         = 1,
    parameter logic [1:0]  STALL_MODE         = 2'b00,
    parameter logic [15:0] LFSR_SEED          = LFSR_DEFAULT_SEED,
    parameter int          TIMEOUT_CYCLES     = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      input_layer_rdy,
    output logic                      input_layer_valid,
    output logic [Nin*BIT_WIDTH-1:0]  input_layer_data,
    input  logic                      output_layer_valid,
    input  logic [Nout*BIT_WIDTH-1:0] output_layer_data,
    output logic                      output_layer_rdy,
    output logic                      stop_sim,
    output logic                      timeout_err,
    output logic [31:0]               rx_beat_cnt,
    output logic [31:0]               checksum
);

    localparam int TX_TOTAL = INPUT_SPATIAL_DIM * FRAME_SIZE;
    localparam int RX_TOTAL = OUTPUT_SPATIAL_DIM * FRAME_SIZE;
    localparam int P_W      = clog2(TX_TOTAL + 1);
    localparam int IDLE_W   = clog2(TIMEOUT_CYCLES + 1);
    localparam int SUM_W    = BIT_WIDTH + clog2(Nout);

    state_e            state_q, state_d;
    logic [P_W-1:0]    pix_q, pix_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic              valid_q, valid_d;
    logic              rdy_q, rdy_d;
    logic              timeout_q, timeout_d;
    logic [31:0]       rx_cnt_q, rx_cnt_d;
    logic [31:0]       checksum_q, checksum_d;
    logic [15:0]       lfsr;
    logic [13:0]       lfsr_unused;
    logic [SUM_W-1:0]  lane_sum;
    logic              tx_hs, rx_hs, tx_last, rx_done, gap, active;

    lfsr16 u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .seed (LFSR_SEED),
        .q    (lfsr)
    );

    // Only the two low bits steer throttling; the rest live in the shift chain.
    assign lfsr_unused = lfsr[15:2];

    always_comb begin
        input_layer_data = '0;
        for (int c = 0; c < Nin; c++) begin
            input_layer_data[c*BIT_WIDTH +: BIT_WIDTH] = BIT_WIDTH'(32'(pix_q) + 32'(c) + 32'd1);
        end
    end

    always_comb begin
        lane_sum = '0;
        for (int c = 0; c < Nout; c++) begin
            lane_sum = lane_sum + SUM_W'(output_layer_data[c*BIT_WIDTH +: BIT_WIDTH]);
        end
    end

    assign tx_hs   = valid_q && input_layer_rdy;
    assign rx_hs   = rdy_q && output_layer_valid;
    assign tx_last = tx_hs && (pix_q == P_W'(TX_TOTAL - 1));
    assign gap     = STALL_MODE[1] && !lfsr[1];
    assign active  = (state_q == ST_SEND) || (state_q == ST_DRAIN);

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        rx_cnt_d   = rx_cnt_q;
        checksum_d = checksum_q;
        if (rx_hs) begin
            if (rx_cnt_q != '1) begin
                rx_cnt_d = rx_cnt_q + 32'd1;
            end
            checksum_d = checksum_q + 32'(lane_sum);
        end
    end

    // Completion is judged on the post-handshake count so rdy drops on the same edge.
    assign rx_done = rx_cnt_d >= 32'(RX_TOTAL);

    always_comb begin
        state_d   = state_q;
        valid_d   = 1'b0;
        pix_d     = pix_q;
        idle_d    = idle_q;
        timeout_d = timeout_q;
        if (tx_hs) begin
            pix_d = pix_q + P_W'(1);
        end
        case (state_q)
            ST_IDLE: state_d = ST_SEND;
            ST_SEND: begin
                if (tx_last) begin
                    state_d = rx_done ? ST_DONE : ST_DRAIN;
                end else if (tx_hs) begin
                    valid_d = !gap;
                end else begin
                    valid_d = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (rx_done) begin
                    state_d = ST_DONE;
                end
            end
            default: ;
        endcase
        if (active) begin
            if (tx_hs || rx_hs) begin
                idle_d = '0;
            end else if (idle_q >= IDLE_W'(TIMEOUT_CYCLES)) begin
                state_d   = ST_DONE;
                timeout_d = 1'b1;
                valid_d   = 1'b0;
            end else begin
                idle_d = idle_q + IDLE_W'(1);
            end
        end
        rdy_d = ((state_d == ST_SEND) || (state_d == ST_DRAIN)) && !rx_done
                && (!STALL_MODE[0] || lfsr[0]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pix_q      <= '0;
            idle_q     <= '0;
            valid_q    <= 1'b0;
            rdy_q      <= 1'b0;
            timeout_q  <= 1'b0;
            rx_cnt_q   <= '0;
            checksum_q <= '0;
        end else begin
            state_q    <= state_d;
            pix_q      <= pix_d;
            idle_q     <= idle_d;
            valid_q    <= valid_d;
            rdy_q      <= rdy_d;
            timeout_q  <= timeout_d;
            rx_cnt_q   <= rx_cnt_d;
            checksum_q <= checksum_d;
        end
    end

    assign input_layer_valid = valid_q;
    assign output_layer_rdy  = rdy_q;
    assign stop_sim          = (state_q == ST_DONE);
    assign timeout_err       = timeout_q;
    assign rx_beat_cnt       = rx_cnt_q;
    assign checksum          = checksum_q;

endmodule

// File: tb/tb_stream_stim_monitor.sv
// Directed bench: four configurations of the stimulus/monitor block, each
// closed through a loopback model that echoes every 25th-in-9 input beat.
module tb_stream_stim_monitor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic bit emits(input int k);
        int kk;
        kk = k % 25;
        return ((kk + 1) * 9 / 25) != (kk * 9 / 25);
    endfunction

    // ---------------- instance A: defaults ----------------
    logic        a_rst = 1'b1, a_in_rdy = 1'b0, a_out_valid = 1'b0;
    logic [23:0] a_out_data = '0;
    logic        a_in_valid, a_out_rdy, a_stop, a_to;
    logic [23:0] a_in_data;
    logic [31:0] a_cnt, a_sum;

    stream_stim_monitor u_a (
        .clk(clk), .rst(a_rst), .input_layer_rdy(a_in_rdy), .input_layer_valid(a_in_valid),
        .input_layer_data(a_in_data), .output_layer_valid(a_out_valid),
        .output_layer_data(a_out_data), .output_layer_rdy(a_out_rdy), .stop_sim(a_stop),
        .timeout_err(a_to), .rx_beat_cnt(a_cnt), .checksum(a_sum)
    );

    logic [23:0] a_q[$], a_log[$], a_tx_d;
    logic        a_tx_p = 1'b0, a_rx_p = 1'b0;
    int          a_tx_n = 0, a_rx_n = 0, a_both_n = 0, a_first = 0, a_last = 0;

    always @(negedge clk) begin
        if (a_rst) begin
            a_q.delete(); a_log.delete();
            a_tx_n = 0; a_rx_n = 0; a_both_n = 0;
            a_tx_p = 1'b0; a_rx_p = 1'b0; a_out_valid = 1'b0;
        end else begin
            if (a_rx_p) begin void'(a_q.pop_front()); a_rx_n++; end
            if (a_tx_p) begin
                if (a_tx_n == 0) a_first = cyc;
                a_last = cyc;
                a_log.push_back(a_tx_d);
                if (emits(a_tx_n)) a_q.push_back(a_tx_d);
                a_tx_n++;
            end
            if (a_tx_p && a_rx_p) a_both_n++;
            a_out_valid = (a_q.size() > 0);
            a_out_data  = a_out_valid ? a_q[0] : '0;
            a_tx_p = a_in_valid && a_in_rdy;
            a_tx_d = a_in_data;
            a_rx_p = a_out_valid && a_out_rdy;
        end
    end

    // ---------------- instance B: 3 frames, 4-bit lanes ----------------
    logic        b_rst = 1'b1, b_in_rdy = 1'b0, b_out_valid = 1'b0;
    logic [11:0] b_out_data = '0;
    logic        b_in_valid, b_out_rdy, b_stop, b_to;
    logic [11:0] b_in_data;
    logic [31:0] b_cnt, b_sum;

    stream_stim_monitor #(.BIT_WIDTH(4), .FRAME_SIZE(3)) u_b (
        .clk(clk), .rst(b_rst), .input_layer_rdy(b_in_rdy), .input_layer_valid(b_in_valid),
        .input_layer_data(b_in_data), .output_layer_valid(b_out_valid),
        .output_layer_data(b_out_data), .output_layer_rdy(b_out_rdy), .stop_sim(b_stop),
        .timeout_err(b_to), .rx_beat_cnt(b_cnt), .checksum(b_sum)
    );

    logic [11:0] b_q[$], b_log[$], b_tx_d;
    logic        b_tx_p = 1'b0, b_rx_p = 1'b0;
    int          b_tx_n = 0, b_rx_n = 0;

    always @(negedge clk) begin
        if (b_rst) begin
            b_q.delete(); b_log.delete();
            b_tx_n = 0; b_rx_n = 0;
            b_tx_p = 1'b0; b_rx_p = 1'b0; b_out_valid = 1'b0;
        end else begin
            if (b_rx_p) begin void'(b_q.pop_front()); b_rx_n++; end
            if (b_tx_p) begin
                b_log.push_back(b_tx_d);
                if (emits(b_tx_n)) b_q.push_back(b_tx_d);
                b_tx_n++;
            end
            b_out_valid = (b_q.size() > 0);
            b_out_data  = b_out_valid ? b_q[0] : '0;
            b_tx_p = b_in_valid && b_in_rdy;
            b_tx_d = b_in_data;
            b_rx_p = b_out_valid && b_out_rdy;
        end
    end

    // ---------------- instance C: full stall mode ----------------
    logic        c_rst = 1'b1, c_in_rdy = 1'b0, c_out_valid = 1'b0;
    logic [23:0] c_out_data = '0;
    logic        c_in_valid, c_out_rdy, c_stop, c_to;
    logic [23:0] c_in_data;
    logic [31:0] c_cnt, c_sum;

    stream_stim_monitor #(.STALL_MODE(2'b11), .LFSR_SEED(16'hACE1)) u_c (
        .clk(clk), .rst(c_rst), .input_layer_rdy(c_in_rdy), .input_layer_valid(c_in_valid),
        .input_layer_data(c_in_data), .output_layer_valid(c_out_valid),
        .output_layer_data(c_out_data), .output_layer_rdy(c_out_rdy), .stop_sim(c_stop),
        .timeout_err(c_to), .rx_beat_cnt(c_cnt), .checksum(c_sum)
    );

    logic [23:0] c_q[$], c_log[$], c_tx_d, c_wait_d;
    logic        c_tx_p = 1'b0, c_rx_p = 1'b0, c_wait = 1'b0;
    int          c_tx_n = 0, c_rx_n = 0, c_viol = 0, c_wait_n = 0;

    // A held beat (valid high, rdy low) must reappear unchanged on the next cycle.
    always @(negedge clk) begin
        if (c_rst) begin
            c_q.delete(); c_log.delete();
            c_tx_n = 0; c_rx_n = 0; c_viol = 0; c_wait_n = 0;
            c_tx_p = 1'b0; c_rx_p = 1'b0; c_wait = 1'b0;
            c_out_valid = 1'b0; c_in_rdy = 1'b0;
        end else begin
            if (c_rx_p) begin void'(c_q.pop_front()); c_rx_n++; end
            if (c_tx_p) begin
                c_log.push_back(c_tx_d);
                if (emits(c_tx_n)) c_q.push_back(c_tx_d);
                c_tx_n++;
            end
            if (c_wait && !(c_in_valid === 1'b1 && c_in_data === c_wait_d)) c_viol++;
            c_out_valid = (c_q.size() > 0);
            c_out_data  = c_out_valid ? c_q[0] : '0;
            c_in_rdy    = (cyc % 3) != 2;
            c_tx_p   = c_in_valid && c_in_rdy;
            c_tx_d   = c_in_data;
            c_rx_p   = c_out_valid && c_out_rdy;
            c_wait   = c_in_valid && !c_in_rdy;
            c_wait_d = c_in_data;
            if (c_wait) c_wait_n++;
        end
    end

    // ---------------- instance D: timeout ----------------
    logic        d_rst = 1'b1, d_in_rdy = 1'b0, d_out_valid = 1'b0;
    logic [23:0] d_out_data = '0;
    logic        d_in_valid, d_out_rdy, d_stop, d_to;
    logic [23:0] d_in_data;
    logic [31:0] d_cnt, d_sum;

    stream_stim_monitor #(.TIMEOUT_CYCLES(16)) u_d (
        .clk(clk), .rst(d_rst), .input_layer_rdy(d_in_rdy), .input_layer_valid(d_in_valid),
        .input_layer_data(d_in_data), .output_layer_valid(d_out_valid),
        .output_layer_data(d_out_data), .output_layer_rdy(d_out_rdy), .stop_sim(d_stop),
        .timeout_err(d_to), .rx_beat_cnt(d_cnt), .checksum(d_sum)
    );

    int b_exp = 0;
    int n;

    initial begin
        tick(); tick(); tick();

        // Reset values
        check("rst_valid", a_in_valid, 0);
        check("rst_out_rdy", a_out_rdy, 0);
        check("rst_stop", a_stop, 0);
        check("rst_timeout", a_to, 0);
        check("rst_cnt", a_cnt, 0);
        check("rst_sum", a_sum, 0);
        check("rst_data", a_in_data, 24'h030201);

        // A: first valid two cycles after release, then reset at pixel 10
        a_in_rdy = 1'b1;
        a_rst = 1'b0;
        tick();
        check("a_valid_c1", a_in_valid, 0);
        tick();
        check("a_valid_c2", a_in_valid, 1);
        for (int i = 0; i < 100 && a_tx_n < 10; i++) tick();
        check("a_reached_pix10", a_tx_n, 10);
        a_rst = 1'b1;
        tick();
        check("mid_rst_valid", a_in_valid, 0);
        check("mid_rst_out_rdy", a_out_rdy, 0);
        check("mid_rst_stop", a_stop, 0);
        check("mid_rst_timeout", a_to, 0);
        check("mid_rst_cnt", a_cnt, 0);
        check("mid_rst_sum", a_sum, 0);
        check("mid_rst_data", a_in_data, 24'h030201);

        // A: full run after restart
        a_rst = 1'b0;
        tick(); tick();
        check("a_restart_valid", a_in_valid, 1);
        check("a_restart_data", a_in_data, 24'h030201);
        for (int i = 0; i < 300 && !a_stop; i++) tick();
        tick(); tick();
        check("a_stop", a_stop, 1);
        check("a_timeout", a_to, 0);
        check("a_rx_cnt", a_cnt, 9);
        check("a_checksum", a_sum, 414);
        check("a_tx_beats", a_tx_n, 25);
        check("a_rx_model", a_rx_n, 9);
        check("a_zero_bubble", a_last - a_first, 24);
        check("a_same_cycle_hs", a_both_n != 0, 1);
        for (int k = 0; k < 25; k++) begin
            logic [23:0] beat;
            beat = a_log[k];
            check($sformatf("a_tx%0d_ch0", k), beat[7:0], k + 1);
            check($sformatf("a_tx%0d_ch1", k), beat[15:8], k + 2);
        end

        // A: extra output beats after completion are refused
        check("a_queue_empty", a_q.size(), 0);
        a_q.push_back(24'h0A0B0C);
        a_q.push_back(24'h010101);
        for (int i = 0; i < 5; i++) tick();
        check("extra_cnt", a_cnt, 9);
        check("extra_sum", a_sum, 414);
        check("extra_left", a_q.size(), 2);
        check("extra_rdy", a_out_rdy, 0);
        a_rst = 1'b1;

        // B: pixel index wraps in 4-bit lanes over 3 frames
        for (int k = 0; k < 75; k++) begin
            if (emits(k)) b_exp += ((k + 1) % 16) + ((k + 2) % 16) + ((k + 3) % 16);
        end
        b_in_rdy = 1'b1;
        b_rst = 1'b0;
        for (int i = 0; i < 500 && !b_stop; i++) tick();
        tick(); tick();
        check("b_stop", b_stop, 1);
        check("b_timeout", b_to, 0);
        check("b_rx_cnt", b_cnt, 27);
        check("b_checksum", b_sum, b_exp);
        check("b_tx_beats", b_tx_n, 75);
        for (int k = 0; k < 75; k++) begin
            logic [11:0] beat;
            beat = b_log[k];
            check($sformatf("b_tx%0d_ch0", k), beat[3:0], (k + 1) % 16);
        end
        b_rst = 1'b1;

        // C: random back-pressure and valid gaps must not change content or order
        c_rst = 1'b0;
        for (int i = 0; i < 2000 && !c_stop; i++) tick();
        tick(); tick();
        check("c_stop", c_stop, 1);
        check("c_timeout", c_to, 0);
        check("c_rx_cnt", c_cnt, 9);
        check("c_checksum", c_sum, 414);
        check("c_tx_beats", c_tx_n, 25);
        check("c_hold_violations", c_viol, 0);
        check("c_waits_seen", c_wait_n != 0, 1);
        for (int k = 0; k < 25; k++) begin
            logic [23:0] beat;
            beat = c_log[k];
            check($sformatf("c_tx%0d_data", k), beat, {8'(k + 3), 8'(k + 2), 8'(k + 1)});
        end
        c_rst = 1'b1;

        // D: input never ready -> timeout abort
        d_rst = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (!d_in_valid && n < 10);
        check("d_first_valid", n, 2);
        for (int i = 0; i < 15; i++) tick();
        check("d_stop_early", d_stop, 0);
        check("d_timeout_early", d_to, 0);
        tick();
        check("d_stop", d_stop, 1);
        check("d_timeout", d_to, 1);
        check("d_rx_cnt", d_cnt, 0);
        check("d_valid_done", d_in_valid, 0);
        d_rst = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
